// File: rtl/wb_multi_arbiter.sv
// wb_multi_arbiter: NM-master to single-slave Wishbone arbiter with fixed or round-robin
// priority, one acked beat per grant, cycle-drop abort and slave-ack timeout.
module wb_multi_arbiter #(
    parameter int NM      = 3,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [4*NM-1:0]  m_sel_i,
    input  logic [DW*NM-1:0] m_dat_i,
    input  logic [AW*NM-1:0] m_adr_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [DW-1:0]    m_dat_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [AW-1:0]    s_adr_o,
    input  logic             s_ack_i,
    input  logic [DW-1:0]    s_dat_i,
    input  logic             rr_en_i,
    output logic [NM-1:0]    grant_o,
    output logic             busy_o
);
    localparam int PW = $clog2(NM);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d, base, gidx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] req, rot, pick, win;
    logic          cyc_g, tmo;

    assign req  = m_stb_i & m_cyc_i;
    assign base = rr_en_i ? ptr_q : '0;
    // Rotate requests so the search always starts at bit 0, then rotate the winner back.
    assign rot  = NM'({req, req} >> base);
    assign win  = NM'({pick, pick} >> (NM - int'(base)));

    always_comb begin
        pick = '0;
        for (int i = NM - 1; i >= 0; i--)
            if (rot[i]) pick = NM'(1) << i;
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NM; i++)
            if (grant_q[i]) gidx = PW'(i);
    end

    assign busy_o  = state_q == BUSY;
    assign grant_o = grant_q;
    assign m_dat_o = s_dat_i;
    assign cyc_g   = busy_o & |(m_cyc_i & grant_q);
    assign tmo     = (TIMEOUT != 0) && busy_o && cnt_q == CW'(TIMEOUT) && !s_ack_i;
    assign m_ack_o = grant_q & {NM{s_ack_i & cyc_g}};
    assign m_err_o = grant_q & {NM{tmo & cyc_g}};

    always_comb begin
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_adr_o = '0;
        for (int i = 0; i < NM; i++)
            if (grant_q[i]) begin
                s_stb_o = m_stb_i[i] & ~tmo;
                s_cyc_o = m_cyc_i[i] & ~tmo;
                s_we_o  = m_we_i[i];
                s_sel_o = m_sel_i[4*i +: 4];
                s_dat_o = m_dat_i[DW*i +: DW];
                s_adr_o = m_adr_i[AW*i +: AW];
            end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = BUSY;
                grant_d = win;
                cnt_d   = CW'(1);
            end
        end else if (!cyc_g || s_ack_i || tmo) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
            ptr_d   = gidx == PW'(NM - 1) ? '0 : gidx + 1'b1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
endmodule

// File: tb/tb_wb_multi_arbiter.sv
// tb_wb_multi_arbiter: directed arbitration scenarios, checked every cycle against a
// behavioural arbiter model plus literal expectations at key points.
module tb_wb_multi_arbiter;
    localparam int NM = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM-1:0]    stb = '0;
    logic [NM-1:0]    cyc = '0;
    logic [NM-1:0]    we = 3'b101;
    logic [4*NM-1:0]  sel = 12'h421;
    logic [DW*NM-1:0] dat = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    logic [AW*NM-1:0] adr = {32'h3000_0200, 32'h2000_0100, 32'h1000_0000};
    logic             ack = 1'b0;
    logic [DW-1:0]    sdat = '0;
    logic             rr = 1'b0;

    logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
    logic [DW-1:0]    m_dat_o, s_dat_o;
    logic [AW-1:0]    s_adr_o;
    logic [3:0]       s_sel_o;
    logic             s_stb_o, s_cyc_o, s_we_o, busy_o;

    int n_chk = 0;
    int n_fail = 0;

    wb_multi_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_stb_i(stb), .m_cyc_i(cyc), .m_we_i(we), .m_sel_i(sel), .m_dat_i(dat), .m_adr_i(adr),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_ack_i(ack), .s_dat_i(sdat),
        .rr_en_i(rr), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic bit_of(logic [NM-1:0] v, int i);
        logic [NM-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int first_req(int p);
        for (int k = 0; k < NM; k++)
            if (bit_of(stb & cyc, (p + k) % NM)) return (p + k) % NM;
        return -1;
    endfunction

    // Model: who holds the bus, for how many cycles, and where round-robin resumes.
    bit mbusy;
    int mg, mptr, mcnt;
    always @(posedge clk or posedge rst)
        if (rst) begin
            mbusy <= 1'b0;
            mg    <= 0;
            mptr  <= 0;
            mcnt  <= 0;
        end else if (!mbusy) begin
            if (first_req(rr ? mptr : 0) >= 0) begin
                mbusy <= 1'b1;
                mg    <= first_req(rr ? mptr : 0);
                mcnt  <= 1;
            end
        end else if (!bit_of(cyc, mg) || ack || mcnt == TO) begin
            mbusy <= 1'b0;
            mptr  <= (mg + 1) % NM;
        end else begin
            mcnt  <= mcnt + 1;
        end

    logic          mcg, mto;
    logic [NM-1:0] moh;
    assign moh = mbusy ? NM'(1) << mg : '0;
    assign mcg = mbusy && bit_of(cyc, mg);
    assign mto = mbusy && mcnt == TO && !ack;

    always @(negedge clk) begin
        check("grant", grant_o, moh);
        check("busy", busy_o, mbusy);
        check("m_ack", m_ack_o, (mcg && ack) ? moh : '0);
        check("m_err", m_err_o, (mcg && mto) ? moh : '0);
        check("s_stb", s_stb_o, mbusy && bit_of(stb, mg) && !mto);
        check("s_cyc", s_cyc_o, mcg && !mto);
        check("s_we", s_we_o, mbusy && bit_of(we, mg));
        check("s_sel", s_sel_o, mbusy ? 4'(sel >> (4 * mg)) : 4'h0);
        check("s_dat", s_dat_o, mbusy ? DW'(dat >> (DW * mg)) : '0);
        check("s_adr", s_adr_o, mbusy ? AW'(adr >> (AW * mg)) : '0);
        check("m_dat", m_dat_o, sdat);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            sdat = sdat + 32'h1357_9BDF;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stb = '0;
        cyc = '0;
        ack = 1'b0;
        we  = 3'b101;
        tick(2);
        rst = 1'b0;
    endtask

    logic [NM-1:0] gs [4];
    int gn;

    initial begin
        @(negedge clk);
        check("rst_grant", grant_o, 3'b000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_stb", s_stb_o, 1'b0);

        do_reset();
        rr = 1'b0; stb = 3'b101; cyc = 3'b101;
        tick(); ack = 1'b1;
        @(negedge clk);
        check("fx_grant0", grant_o, 3'b001);
        check("fx_stb_lat", s_stb_o, 1'b1);
        check("fx_adr0", s_adr_o, 32'h1000_0000);
        check("fx_ack0", m_ack_o, 3'b001);
        tick(); ack = 1'b0; stb = 3'b100; cyc = 3'b100;
        @(negedge clk);
        check("fx_gap", grant_o, 3'b000);
        tick(); ack = 1'b1;
        @(negedge clk);
        check("fx_grant2", grant_o, 3'b100);
        check("fx_ack2", m_ack_o, 3'b100);
        tick(); stb = '0; cyc = '0; ack = 1'b0;

        do_reset();
        rr = 1'b1; stb = 3'b111; cyc = 3'b111; ack = 1'b1; gn = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            if (grant_o != '0 && gn < 4) begin
                gs[gn] = grant_o;
                gn++;
            end
        end
        check("rr_count", gn, 4);
        check("rr_g0", gs[0], 3'b001);
        check("rr_g1", gs[1], 3'b010);
        check("rr_g2", gs[2], 3'b100);
        check("rr_g3", gs[3], 3'b001);
        tick(); stb = '0; cyc = '0; ack = 1'b0;

        do_reset();
        rr = 1'b1; stb = 3'b010; cyc = 3'b010;
        tick(3);
        @(negedge clk);
        check("to_noerr_c3", m_err_o, 3'b000);
        tick();
        @(negedge clk);
        check("to_err_c4", m_err_o, 3'b010);
        check("to_stb_off", s_stb_o, 1'b0);
        check("to_cyc_off", s_cyc_o, 1'b0);
        tick(); stb = 3'b101; cyc = 3'b101;
        @(negedge clk);
        check("to_idle", busy_o, 1'b0);
        check("to_err_gone", m_err_o, 3'b000);
        tick();
        @(negedge clk);
        check("to_ptr_adv", grant_o, 3'b100);
        tick(); stb = '0; cyc = '0;

        do_reset();
        rr = 1'b0; stb = 3'b001; cyc = 3'b001;
        tick(4); ack = 1'b1;
        @(negedge clk);
        check("col_ack", m_ack_o, 3'b001);
        check("col_err", m_err_o, 3'b000);
        tick(); ack = 1'b0; stb = '0; cyc = '0;
        @(negedge clk);
        check("col_idle", busy_o, 1'b0);

        do_reset();
        rr = 1'b0; stb = 3'b010; cyc = 3'b010;
        tick();
        @(negedge clk);
        check("ab_grant", grant_o, 3'b010);
        tick(); cyc = 3'b000; ack = 1'b1;
        @(negedge clk);
        check("ab_noack", m_ack_o, 3'b000);
        check("ab_noerr", m_err_o, 3'b000);
        tick(); ack = 1'b0; stb = '0;
        @(negedge clk);
        check("ab_idle", busy_o, 1'b0);

        do_reset();
        rr = 1'b1; stb = 3'b001; cyc = 3'b001; ack = 1'b1;
        tick(2); ack = 1'b0; stb = 3'b010; cyc = 3'b010; we = 3'b111;
        tick();
        @(negedge clk);
        check("rw_grant1", grant_o, 3'b010);
        check("rw_we", s_we_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rw_stb_async", s_stb_o, 1'b0);
        check("rw_grant_async", grant_o, 3'b000);
        check("rw_busy_async", busy_o, 1'b0);
        stb = 3'b111; cyc = 3'b111;
        tick(); rst = 1'b0;
        tick();
        @(negedge clk);
        check("rw_first", grant_o, 3'b001);
        tick(); stb = '0; cyc = '0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
